// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter driving open-drain clk/data lines.
// Define PS2_HOST_TX_TIMEOUT_EN to abort a frame when the device stops clocking.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    inout  wire        ps2_clk,
    inout  wire        ps2_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err
);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE} state_t;
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    state_t        state, state_nx;
    logic [IW-1:0] inh_cnt;
    logic [1:0]    clk_sync, data_sync;
    logic          clk_prev, fall;
    logic [9:0]    sh;
    logic [3:0]    bit_idx;
    logic          bit_oe, to_hit, done_nx, err_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_prev  <= clk_sync[1];
        end
    end
    assign fall = clk_prev & ~clk_sync[1];

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            IDLE:      if (tx_start) state_nx = INHIBIT;
            INHIBIT:   if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) state_nx = REQ;
            REQ:       state_nx = SHIFT;
            SHIFT:     if (fall && bit_idx == 4'd9) state_nx = ACK;
            ACK: if (fall) begin
                state_nx = data_sync[1] ? IDLE : WAIT_IDLE;
                err_nx   = data_sync[1];
            end
            WAIT_IDLE: if (clk_sync[1] && data_sync[1]) begin
                state_nx = IDLE;
                done_nx  = 1'b1;
            end
            default:   state_nx = IDLE;
        endcase
        if (to_hit) begin
            state_nx = IDLE;
            done_nx  = 1'b0;
            err_nx   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
        end else begin
            state   <= state_nx;
            tx_busy <= state_nx != IDLE;
            tx_done <= done_nx;
            tx_err  <= err_nx;
        end
    end

    // sh holds {stop, parity, data}; each device falling edge presents the next bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inh_cnt <= '0;
            sh      <= '0;
            bit_idx <= '0;
            bit_oe  <= 1'b0;
        end else begin
            inh_cnt <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
            if (state == IDLE && tx_start)
                sh <= {1'b1, ~^tx_data, tx_data};
            if (state == REQ) begin
                bit_oe  <= 1'b1;
                bit_idx <= '0;
            end else if (state == SHIFT && fall) begin
                bit_oe  <= ~sh[0];
                sh      <= sh >> 1;
                bit_idx <= bit_idx + 1'b1;
            end else if (state != SHIFT) begin
                bit_oe  <= 1'b0;
            end
        end
    end

`ifdef PS2_HOST_TX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
    logic          to_run;
    assign to_run = state inside {SHIFT, ACK, WAIT_IDLE};
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else
            to_cnt <= to_run ? to_cnt + 1'b1 : '0;
    end
    assign to_hit = to_run && to_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
    assign to_hit = TIMEOUT_CYCLES < 0;
`endif

    assign ps2_clk  = (state == INHIBIT || state == REQ) ? 1'b0 : 1'bz;
    assign ps2_data = (state == REQ || (state == SHIFT && bit_oe)) ? 1'b0 : 1'bz;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a small PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 200;
    localparam int TO   = 3000;
    localparam int HALF = 25;

    logic       clk = 1'b0, rst = 1'b0, tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_busy, tx_done, tx_err;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    wire        ps2_clk, ps2_data;
    int         n_tests = 0, n_fail = 0;
    int         done_cnt = 0, err_cnt = 0, overlap = 0, busy_on_done = 0, inh_cnt = 0;
    logic [9:0] bits;

    pullup(ps2_clk);
    pullup(ps2_data);
    assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
    assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .tx_start(tx_start), .tx_data(tx_data),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    always begin
        @(negedge clk);
        #1;
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
        if (tx_done && tx_err) overlap++;
        if ((tx_done || tx_err) && tx_busy) busy_on_done++;
        if (ps2_clk === 1'b0 && ps2_data === 1'b1 && !dev_clk_low) inh_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic dev_frame(input int n, input bit ack, output logic [9:0] b);
        int k = 0;
        b = '1;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("req_seen", 32'(k < 5000), 1);
        for (int i = 0; i < n; i++) begin
            repeat (HALF) @(negedge clk);
            if (i == 10) dev_data_low = ack;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_clk_low = 1'b0;
            if (i < 10) b[i] = ps2_data;
        end
        if (n == 11) begin
            repeat (HALF) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (tx_busy && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(tx_busy), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int d0, e0, i0, k;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(tx_busy), 0);
        chk("rst_done", 32'(tx_done), 0);
        chk("rst_err", 32'(tx_err), 0);
        chk("rst_clk_line", 32'(ps2_clk), 1);
        chk("rst_data_line", 32'(ps2_data), 1);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        start(8'hED);
        dev_frame(11, 1'b1, bits);
        wait_idle("ed_end");
        chk("ed_data", 32'(bits[7:0]), 32'hED);
        chk("ed_parity", 32'(bits[8]), 1);
        chk("ed_stop", 32'(bits[9]), 1);
        chk("ed_done", done_cnt - d0, 1);
        chk("ed_err", err_cnt - e0, 0);
        chk("ed_inhibit", inh_cnt - i0, INH);

        d0 = done_cnt; e0 = err_cnt; i0 = inh_cnt;
        start(8'h00);
        dev_frame(11, 1'b1, bits);
        wait_idle("z_end");
        chk("z_data", 32'(bits[7:0]), 0);
        chk("z_parity", 32'(bits[8]), 1);
        chk("z_inhibit", inh_cnt - i0, INH);
        chk("z_done", done_cnt - d0, 1);

        d0 = done_cnt; e0 = err_cnt;
        start(8'h5A);
        dev_frame(11, 1'b0, bits);
        wait_idle("nack_end");
        chk("nack_data", 32'(bits[7:0]), 32'h5A);
        chk("nack_parity", 32'(bits[8]), 1);
        chk("nack_err", err_cnt - e0, 1);
        chk("nack_done", done_cnt - d0, 0);

        d0 = done_cnt; e0 = err_cnt;
        start(8'hF4);
        fork
            dev_frame(11, 1'b1, bits);
            begin
                repeat (400) @(negedge clk);
                start(8'h55);
            end
        join
        wait_idle("ign_end");
        chk("ign_data", 32'(bits[7:0]), 32'hF4);
        chk("ign_parity", 32'(bits[8]), 0);
        repeat (3 * INH) @(negedge clk);
        chk("ign_busy", 32'(tx_busy), 0);
        chk("ign_clk_line", 32'(ps2_clk), 1);
        chk("ign_done", done_cnt - d0, 1);

        d0 = done_cnt; e0 = err_cnt;
        start(8'h37);
        dev_frame(4, 1'b0, bits);
        chk("ab_bits", 32'(bits[3:0]), 32'h7);
        chk("ab_pre_data", 32'(ps2_data), 0);
        rst = 1'b0;
        #1;
        chk("ab_clk_line", 32'(ps2_clk), 1);
        chk("ab_data_line", 32'(ps2_data), 1);
        chk("ab_busy", 32'(tx_busy), 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (INH) @(negedge clk);
        chk("ab_no_done", done_cnt - d0, 0);
        chk("ab_no_err", err_cnt - e0, 0);
        start(8'hA5);
        dev_frame(11, 1'b1, bits);
        wait_idle("ab2_end");
        chk("ab2_data", 32'(bits[7:0]), 32'hA5);
        chk("ab2_parity", 32'(bits[8]), 1);
        chk("ab2_done", done_cnt - d0, 1);

`ifdef PS2_HOST_TX_TIMEOUT_EN
        d0 = done_cnt; e0 = err_cnt;
        start(8'h12);
        k = 0;
        while (!(ps2_clk === 1'b1 && ps2_data === 1'b0) && k < 5000) begin
            @(negedge clk);
            k++;
        end
        chk("to_release", 32'(k < 5000), 1);
        k = 0;
        while (!tx_err && k < TO + 100) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", k, TO);
        chk("to_clk_line", 32'(ps2_clk), 1);
        chk("to_data_line", 32'(ps2_data), 1);
        chk("to_busy", 32'(tx_busy), 0);
        repeat (2) @(negedge clk);
        chk("to_err", err_cnt - e0, 1);
        chk("to_done", done_cnt - d0, 0);
`endif

        chk("done_err_overlap", overlap, 0);
        chk("busy_at_pulse", busy_on_done, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
